// File: rtl/cpu_out_uart_tx.sv
// Serialises 32-bit words from the CPU out port as four 8N1 UART frames, low byte first.
// A single-entry holding buffer lets the CPU queue the next word while a frame is on the line.
module cpu_out_uart_tx #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        tx,
    output logic        busy,
    output logic [15:0] word_count
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    localparam logic [15:0] LAST_CLK = 16'(CLKS_PER_BIT - 1);

    state_t      state, state_next;
    logic [31:0] buf_data;
    logic        buf_full, buf_full_next;
    logic [31:0] shift, shift_next;
    logic [15:0] bit_cnt, bit_cnt_next;
    logic [1:0]  byte_idx, byte_idx_next;
    logic [2:0]  bit_idx, bit_idx_next;
    logic        tx_next;
    logic [15:0] count_next;
    logic        accept;
    logic        bit_done;

    assign in_ready = ~buf_full;
    assign accept   = in_valid & ~buf_full;
    assign bit_done = (bit_cnt == LAST_CLK);
    assign busy     = (state != IDLE) | buf_full;

    // Register file: FSM, counters, buffer and the registered serial output
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            tx         <= 1'b1;
            buf_full   <= 1'b0;
            buf_data   <= '0;
            shift      <= '0;
            bit_cnt    <= '0;
            byte_idx   <= '0;
            bit_idx    <= '0;
            word_count <= '0;
        end else begin
            state      <= state_next;
            tx         <= tx_next;
            buf_full   <= buf_full_next;
            shift      <= shift_next;
            bit_cnt    <= bit_cnt_next;
            byte_idx   <= byte_idx_next;
            bit_idx    <= bit_idx_next;
            word_count <= count_next;
            if (accept) begin
                buf_data <= in_data;
            end
        end
    end

    // The shift register moves right once per data bit, so after eight shifts the
    // next byte already sits in shift[7:0] when its start bit begins.
    always_comb begin
        state_next    = state;
        tx_next       = tx;
        buf_full_next = buf_full;
        shift_next    = shift;
        bit_cnt_next  = bit_cnt + 16'd1;
        byte_idx_next = byte_idx;
        bit_idx_next  = bit_idx;
        count_next    = word_count;

        if (accept) begin
            buf_full_next = 1'b1;
        end

        case (state)
            IDLE: begin
                bit_cnt_next = '0;
                tx_next      = 1'b1;
                if (buf_full) begin
                    shift_next    = buf_data;
                    buf_full_next = 1'b0;
                    byte_idx_next = '0;
                    bit_idx_next  = '0;
                    state_next    = START;
                    tx_next       = 1'b0;
                end
            end
            START: begin
                if (bit_done) begin
                    bit_cnt_next = '0;
                    bit_idx_next = '0;
                    state_next   = DATA;
                    tx_next      = shift[0];
                end
            end
            DATA: begin
                if (bit_done) begin
                    bit_cnt_next = '0;
                    shift_next   = {1'b0, shift[31:1]};
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                        tx_next    = 1'b1;
                    end else begin
                        bit_idx_next = bit_idx + 3'd1;
                        tx_next      = shift[1];
                    end
                end
            end
            STOP: begin
                if (bit_done) begin
                    bit_cnt_next = '0;
                    if (byte_idx == 2'd3) begin
                        state_next = IDLE;
                        tx_next    = 1'b1;
                        count_next = word_count + 16'd1;
                    end else begin
                        byte_idx_next = byte_idx + 2'd1;
                        state_next    = START;
                        tx_next       = 1'b0;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                tx_next    = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_cpu_out_uart_tx.sv
// Directed bench for cpu_out_uart_tx: one instance at 4 clocks/bit, one at 2 clocks/bit,
// with a bit-sampling receiver and hand-computed expected words, latencies and counts.
module tb_cpu_out_uart_tx;

    localparam int CA = 4;
    localparam int CB = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] data_a = '0, data_b = '0;
    logic        valid_a = 1'b0, valid_b = 1'b0;
    logic        ready_a, tx_a, busy_a, ready_b, tx_b, busy_b;
    logic [15:0] count_a, count_b;

    int cyc = 0;
    int checks = 0;
    int passed = 0;

    cpu_out_uart_tx #(.CLKS_PER_BIT(CA)) dut_a (
        .clock(clock), .reset(reset), .in_data(data_a), .in_valid(valid_a),
        .in_ready(ready_a), .tx(tx_a), .busy(busy_a), .word_count(count_a)
    );

    cpu_out_uart_tx #(.CLKS_PER_BIT(CB)) dut_b (
        .clock(clock), .reset(reset), .in_data(data_b), .in_valid(valid_b),
        .in_ready(ready_b), .tx(tx_b), .busy(busy_b), .word_count(count_b)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, %0d/%0d so far", passed, checks);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed === expected) passed++;
        else $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    function automatic logic txOf(input bit sel);
        return sel ? tx_b : tx_a;
    endfunction

    // Holds the word valid until an edge where in_ready was high; reports that edge
    task automatic applyStimulus(input bit sel, input logic [31:0] word, output int acc_cyc, output int waited);
        logic rdy;
        acc_cyc = -1;
        waited  = 0;
        if (sel) begin data_b = word; valid_b = 1'b1; end
        else     begin data_a = word; valid_a = 1'b1; end
        for (int i = 0; i < 1000; i++) begin
            rdy = sel ? ready_b : ready_a;
            @(posedge clock);
            #1;
            if (rdy) begin
                acc_cyc = cyc;
                break;
            end
            waited++;
        end
        if (sel) valid_b = 1'b0;
        else     valid_a = 1'b0;
        if (acc_cyc < 0) checkOutput("accept_timeout", 32'd1, 32'd0);
    endtask

    // Called just after the edge that starts a start bit; samples each bit mid-cell
    task automatic captureByte(input bit sel, input int c, output logic [7:0] b, output int ferr);
        logic [9:0] bits;
        for (int k = 0; k < 10; k++) begin
            tick(c / 2);
            bits[k] = txOf(sel);
            tick(c - c / 2);
        end
        b = bits[8:1];
        ferr = 0;
        if (bits[0] !== 1'b0) ferr++;
        if (bits[9] !== 1'b1) ferr++;
    endtask

    task automatic receiveWord(input bit sel, input int c, output logic [31:0] w, output int ferr);
        logic [7:0] b;
        int e;
        ferr = 0;
        for (int j = 0; j < 4; j++) begin
            captureByte(sel, c, b, e);
            w[8*j +: 8] = b;
            ferr += e;
        end
    endtask

    initial begin
        int acc1, acc2, acc3, wt1, wt2, wt3, ferr, lows, mism;
        logic [31:0] w, r1, r2, r3;

        // Asynchronous reset, observed before any clock edge
        #2 reset = 1'b1;
        #1;
        checkOutput("reset_tx", tx_a, 1);
        checkOutput("reset_ready", ready_a, 1);
        checkOutput("reset_busy", busy_a, 0);
        checkOutput("reset_count", count_a, 0);
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b0;

        // Single word, accepted on the very first edge after reset
        applyStimulus(0, 32'h0000_00A5, acc1, wt1);
        checkOutput("a5_first_edge_accept", wt1, 0);
        checkOutput("a5_busy_after_accept", busy_a, 1);
        checkOutput("a5_tx_idle_at_accept", tx_a, 1);
        tick(1);
        checkOutput("a5_start_latency", tx_a, 0);
        receiveWord(0, CA, w, ferr);
        checkOutput("a5_word", w, 32'h0000_00A5);
        checkOutput("a5_framing", ferr, 0);
        checkOutput("a5_tx_after", tx_a, 1);
        checkOutput("a5_count", count_a, 1);
        checkOutput("a5_busy_after", busy_a, 0);

        // Three words back to back; the third stalls on a full buffer
        fork
            begin
                applyStimulus(0, 32'h1234_5678, acc1, wt1);
                applyStimulus(0, 32'hDEAD_BEEF, acc2, wt2);
                applyStimulus(0, 32'h0BAD_C0DE, acc3, wt3);
            end
            begin
                for (int i = 0; i < 20; i++) begin
                    tick(1);
                    if (tx_a == 1'b0) break;
                end
                receiveWord(0, CA, r1, ferr);
                checkOutput("b2b_w1_framing", ferr, 0);
                checkOutput("b2b_gap1_idle", tx_a, 1);
                tick(1);
                checkOutput("b2b_gap1_start", tx_a, 0);
                receiveWord(0, CA, r2, ferr);
                checkOutput("b2b_w2_framing", ferr, 0);
                checkOutput("b2b_gap2_idle", tx_a, 1);
                tick(1);
                checkOutput("b2b_gap2_start", tx_a, 0);
                receiveWord(0, CA, r3, ferr);
                checkOutput("b2b_w3_framing", ferr, 0);
            end
        join
        checkOutput("b2b_w1", r1, 32'h1234_5678);
        checkOutput("b2b_w2", r2, 32'hDEAD_BEEF);
        checkOutput("b2b_w3", r3, 32'h0BAD_C0DE);
        checkOutput("b2b_acc2_offset", acc2 - acc1, 2);
        checkOutput("b2b_acc2_wait", wt2, 1);
        checkOutput("b2b_acc3_offset", acc3 - acc1, 163);
        checkOutput("b2b_acc3_stall", wt3, 160);
        checkOutput("b2b_count", count_a, 4);
        checkOutput("b2b_busy_after", busy_a, 0);

        // Reset in the middle of byte 2, with a second word sitting in the buffer
        applyStimulus(0, 32'hCAFE_F00D, acc1, wt1);
        applyStimulus(0, 32'h1111_1111, acc2, wt2);
        tick(20 * CA + 5);
        checkOutput("rst_tx_low_before", tx_a, 0);
        #3 reset = 1'b1;
        #1;
        checkOutput("rst_tx", tx_a, 1);
        checkOutput("rst_count", count_a, 0);
        checkOutput("rst_busy", busy_a, 0);
        checkOutput("rst_ready", ready_a, 1);
        @(posedge clock); #1;
        reset = 1'b0;
        lows = 0;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            if (tx_a !== 1'b1) lows++;
        end
        checkOutput("rst_no_activity", lows, 0);
        checkOutput("rst_busy_after", busy_a, 0);

        // Counter wrap from 0xFFFF
        force dut_a.word_count = 16'hFFFF;
        #1;
        release dut_a.word_count;
        @(posedge clock); #1;
        checkOutput("wrap_preset", count_a, 32'h0000_FFFF);
        applyStimulus(0, 32'h89AB_CDEF, acc1, wt1);
        tick(1);
        receiveWord(0, CA, w, ferr);
        checkOutput("wrap_word", w, 32'h89AB_CDEF);
        checkOutput("wrap_count", count_a, 0);

        // Two clocks per bit: all-ones word, check every cycle of the frame
        applyStimulus(1, 32'hFFFF_FFFF, acc1, wt1);
        tick(1);
        mism = 0;
        for (int i = 0; i < 80; i++) begin
            if (txOf(1) !== ((i % 20) >= 2)) mism++;
            if (i == 79) checkOutput("cb2_busy_last_cycle", busy_b, 1);
            tick(1);
        end
        checkOutput("cb2_pattern", mism, 0);
        checkOutput("cb2_tx_after", tx_b, 1);
        checkOutput("cb2_busy_after", busy_b, 0);
        checkOutput("cb2_count", count_b, 1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
